iter_mul: RTL and testbench

ITER_MUL -- requirements
Module: iter_mul

---
 rtl/iter_mul_pkg.sv | 18 +
 rtl/iter_mul_step.sv | 25 ++
 rtl/iter_mul.sv | 119 +++++++++++
 tb/tb_iter_mul.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/iter_mul_pkg.sv
// iter_mul_pkg: shared FSM state encoding and default geometry for iter_mul.
// Revision: 1.0
`default_nettype none

package iter_mul_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_STEP  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/iter_mul_step.sv
// iter_mul_step: combinational WIDTH x STEP partial product (multiplicand times a STEP-bit digit).
// Revision: 1.0
`default_nettype none

module iter_mul_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 2
) (
  input  logic [WIDTH-1:0]      mcand,
  input  logic [STEP-1:0]       bits,
  output logic [WIDTH+STEP-1:0] pp
);

  always_comb begin
    pp = '0;
    for (int i = 0; i < STEP; i++) begin
      if (bits[i]) begin
        pp = pp + ({{STEP{1'b0}}, mcand} << i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/iter_mul.sv
// iter_mul: iterative STEP-bits-per-cycle multiplier returning either half of the 2*WIDTH product.
// Revision: 1.0 -- signed operands compiled in only when ITER_MUL_SIGNED_EN is defined.
`default_nettype none

module iter_mul
  import iter_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [WIDTH-1:0] p0,
  input  logic [WIDTH-1:0] p1,
  input  logic             sgn,
  input  logic             hi,
  output logic             busy,
  output logic             ack,
  output logic [WIDTH-1:0] out
);

  localparam int ITERS = WIDTH / STEP;
  localparam int CW    = $clog2(ITERS + 1);
  localparam int PW    = $clog2(2 * WIDTH);

  state_t               state, state_nx;
  logic [WIDTH-1:0]     mcand, mplier;
  logic [2*WIDTH-1:0]   acc, pp_ext, prod;
  logic [CW-1:0]        cnt;
  logic                 hi_q;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH+STEP-1:0] pp;
  logic [PW-1:0]        pos;
  logic                 accept;

  assign accept = (state == IDLE) && req;

`ifdef ITER_MUL_SIGNED_EN
  // Magnitudes are formed before iterating; -2^(WIDTH-1) maps to itself as an unsigned value.
  logic neg_q;
  assign a_mag = (sgn && p0[WIDTH-1]) ? -p0 : p0;
  assign b_mag = (sgn && p1[WIDTH-1]) ? -p1 : p1;
  assign prod  = neg_q ? -acc : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else if (accept) begin
      neg_q <= sgn & (p0[WIDTH-1] ^ p1[WIDTH-1]);
    end
  end
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign a_mag      = p0;
  assign b_mag      = p1;
  assign prod       = acc;
`endif

  iter_mul_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .mcand (mcand),
    .bits  (mplier[STEP-1:0]),
    .pp    (pp)
  );

  assign pos    = PW'((ITERS - int'(cnt)) * STEP);
  assign pp_ext = {{(WIDTH-STEP){1'b0}}, pp} << pos;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = BUSY;
      BUSY:    if (cnt == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The cycle after the last digit resolves sign and half-select into out.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      hi_q   <= 1'b0;
      out    <= '0;
    end else if (accept) begin
      mcand  <= a_mag;
      mplier <= b_mag;
      acc    <= '0;
      cnt    <= CW'(ITERS);
      hi_q   <= hi;
    end else if (state == BUSY) begin
      if (cnt != '0) begin
        acc    <= acc + pp_ext;
        mplier <= mplier >> STEP;
        cnt    <= cnt - CW'(1);
      end else begin
        out <= hi_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
      end
    end
  end

  assign busy = (state == BUSY) || (state == DONE);
  assign ack  = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_iter_mul.sv
// tb_iter_mul: directed self-checking bench for iter_mul at WIDTH=32, STEP=2.
// Revision: 1.0
`default_nettype none

module tb_iter_mul;

  logic        clk = 1'b0;
  logic        rst, req, sgn, hi;
  logic [31:0] p0, p1;
  logic        busy, ack;
  logic [31:0] out;

  int vectors     = 0;
  int miscompares = 0;

  iter_mul #(.WIDTH(32), .STEP(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .p0   (p0),
    .p1   (p1),
    .sgn  (sgn),
    .hi   (hi),
    .busy (busy),
    .ack  (ack),
    .out  (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE, scramble operands after acceptance, wait for ack.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic h, input logic [31:0] exp);
    int lat;
    logic [31:0] res;
    lat = 0;
    res = '0;
    req = 1'b1; p0 = a; p1 = b; sgn = s; hi = h;
    tick();
    req = 1'b0; p0 = ~a; p1 = ~b; sgn = ~s; hi = ~h;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ack) begin
        lat = k;
        res = out;
        break;
      end
    end
    check({tag, " out"}, res, exp);
    check({tag, " latency"}, lat, 32'd17);
    tick();
  endtask

  initial begin
    int acks, lat, busy_seen, bad, t0, t1, t2;
    logic [31:0] res, prev;

    rst = 1'b1; req = 1'b0; p0 = '0; p1 = '0; sgn = 1'b0; hi = 1'b0;
    tick(); tick();
    check("reset busy", busy, 0);
    check("reset ack", ack, 0);
    check("reset out", out, 0);
    rst = 1'b0;
    tick();

    run_op("3*5 lo", 32'd3, 32'd5, 1'b0, 1'b0, 32'h0000000F);
    run_op("ffff^2 hi", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFE);
    run_op("ffff^2 lo", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000001);
    run_op("zero", 32'h0, 32'h12345678, 1'b0, 1'b0, 32'h0);
    run_op("2^16^2 hi", 32'h00010000, 32'h00010000, 1'b0, 1'b1, 32'h00000001);
    run_op("x16 lo", 32'h12345678, 32'h10, 1'b0, 1'b0, 32'h23456780);
    run_op("x16 hi", 32'h12345678, 32'h10, 1'b0, 1'b1, 32'h00000001);
    run_op("x1 lo", 32'hDEADBEEF, 32'h1, 1'b0, 1'b0, 32'hDEADBEEF);
`ifdef ITER_MUL_SIGNED_EN
    run_op("s -3*7 lo", 32'hFFFFFFFD, 32'd7, 1'b1, 1'b0, 32'hFFFFFFEB);
    run_op("s -3*7 hi", 32'hFFFFFFFD, 32'd7, 1'b1, 1'b1, 32'hFFFFFFFF);
    run_op("s min^2 hi", 32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h40000000);
    run_op("s min^2 lo", 32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'h00000000);
`else
    run_op("sgn ignored hi", 32'hFFFFFFFD, 32'd7, 1'b1, 1'b1, 32'h00000006);
    run_op("sgn ignored lo", 32'hFFFFFFFD, 32'd7, 1'b1, 1'b0, 32'hFFFFFFEB);
`endif

    // Request pulsed mid-operation must be dropped.
    acks = 0; lat = 0; res = '0;
    req = 1'b1; p0 = 32'd6; p1 = 32'd7; sgn = 1'b0; hi = 1'b0;
    tick();
    req = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 4) begin req = 1'b1; p0 = 32'd99; p1 = 32'd99; end
      if (k == 6) req = 1'b0;
      tick();
      if (ack) begin
        acks++;
        if (acks == 1) begin lat = k; res = out; end
      end
    end
    check("busy req acks", acks, 1);
    check("busy req out", res, 32'd42);
    check("busy req latency", lat, 17);

    // Reset during BUSY aborts without ack; req in the reset cycle is ignored.
    req = 1'b1; p0 = 32'd6; p1 = 32'd7;
    tick();
    req = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    rst = 1'b1; req = 1'b1;
    tick();
    rst = 1'b0; req = 1'b0;
    check("abort busy", busy, 0);
    check("abort out", out, 0);
    acks = 0; busy_seen = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (ack) acks++;
      if (busy) busy_seen++;
    end
    check("abort acks", acks, 0);
    check("abort no restart", busy_seen, 0);
    run_op("after abort 2*2", 32'd2, 32'd2, 1'b0, 1'b0, 32'd4);

    // Held request: back-to-back ops every 19 cycles, out moves only on ack.
    acks = 0; bad = 0; t0 = 0; t1 = 0; t2 = 0;
    prev = out;
    req = 1'b1; p0 = 32'd3; p1 = 32'd5; sgn = 1'b0; hi = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (ack) begin
        acks++;
        if (acks == 1) t0 = k;
        if (acks == 2) t1 = k;
        if (acks == 3) t2 = k;
      end
      if (out !== prev && !ack) bad++;
      prev = out;
    end
    req = 1'b0;
    check("held acks", acks, 4);
    check("held first", t0, 18);
    check("held gap1", t1 - t0, 19);
    check("held gap2", t2 - t1, 19);
    check("held out stable", bad, 0);
    check("held out", out, 32'd15);
    for (int k = 1; k <= 25; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
